rv_decode_stage: RTL
====================

Name: rv_decode_stage

Overview:
- Registered RV32I/RV64I instruction decode stage, parametrised successor to the team's combinational field decoder.
- Sits between fetch and the register-read/execute stages.
- Full field extraction, immediate generation sign-extended to XLEN, format classification and illegal-instruction detection.
- valid/ready handshake on both sides; 2-entry skid buffer so in_ready is a registered signal; synchronous flush for branch redirect.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; sets imm and pc widths; 64 also enables OP-IMM-32/OP-32.
- PC_PASS, 1, when 1 the pc sideband is carried with the instruction; when 0, out_pc is tied to 0.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; drops all held and incoming instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  pc of the decoded instruction
- out_opcode  out  7  instr[6:0]
- out_rd  out  5  destination register
- out_rs1  out  5  source register 1
- out_rs2  out  5  source register 2
- out_funct3  out  3  funct3
- out_funct7  out  7  funct7
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
- out_illegal  out  1  instruction not decodable

Behaviour:
- Reset: all out_* = 0, out_valid = 0, skid empty, in_ready = 1.
- Latency: 1 cycle, accept edge to out_valid.
- Transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Skid buffer:
  - in_ready = ~skid_valid, driven from a flop.
  - When the main register is held (out_valid & ~out_ready) and an input is accepted, the input goes to skid.
  - On an output transfer, skid moves to main; a same-cycle input then goes to skid.
  - Order is always preserved.
- Flush:
  - Next cycle: out_valid = 0, skid empty, in_ready = 1.
  - An input presented in the flush cycle is dropped.
  - Flush has priority over all other events.
- Format classes:
  - R: 0110011 (OP); also 0111011 (OP-32) when XLEN=64.
  - I: 0000011 (LOAD), 0010011 (OP-IMM), 1100111 (JALR), 0001111 (FENCE), 1110011 (SYSTEM); also 0011011 (OP-IMM-32) when XLEN=64.
  - S: 0100011 (STORE).
  - B: 1100011 (BRANCH).
  - U: 0110111 (LUI), 0010111 (AUIPC).
  - J: 1101111 (JAL).
- Illegal when any of:
  - in_instr[1:0] != 11;
  - unlisted opcode;
  - JALR with funct3 != 000;
  - BRANCH with funct3 = 010 or 011;
  - any 64-bit-only opcode when XLEN=32.
- Illegal output: out_illegal = 1, fmt = 7; opcode and pc still reported; every other field and imm = 0.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R: 0
- Unused fields are driven to 0 (no latches):
  - rd = 0 for S and B;
  - rs1 = 0 for U and J;
  - rs2 = 0 for I, U and J;
  - funct3 = 0 for U and J;
  - funct7 nonzero only for R.
- Output stability: while out_valid & ~out_ready, all out_* hold stable.
- Reset mid-stall: asynchronous clear to reset values; no instruction survives.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), XLEN=32 -> fmt=1, rd=1, rs1=0, rs2=0, funct3=0, imm=0xFFFFFFFF, out_valid one cycle after accept.
- 0xFE512E23 (sw x5,-4(x2)) -> fmt=2, rd=0, rs1=2, rs2=5, funct3=2, imm=0xFFFFFFFC; 0x001000EF (jal x1,2048) -> fmt=5, rd=1, imm=0x00000800.
- XLEN=64, 0x800001B7 (lui x3,0x80000) -> fmt=4, rd=3, imm=0xFFFFFFFF80000000; same word at XLEN=32 -> imm=0x80000000.
- 0x00000000, 0x0000706F (jal with [1:0]=11 but funct3 ignored, legal), and 0x00001067 (jalr funct3=1) -> first and third give illegal=1, fmt=7, imm=0; second gives fmt=5.
- out_ready=0 while streaming A, B, C each cycle -> in_ready falls after B is accepted, C is held off; releasing out_ready yields A, B, C in order with no loss or duplication.
- flush asserted with main and skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted afterwards; rst_n pulsed mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for the decode stage.
// master = fetch/downstream driver, slave = the decode stage itself.
interface rv_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode,
    input  out_rd, out_rs1, out_rs2, out_funct3,
    input  out_funct7, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode,
    output out_rd, out_rs1, out_rs2, out_funct3,
    output out_funct7, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I decode stage with a 2-entry skid buffer.
// Decodes on entry; main and skid registers hold finished bundles.
module rv_decode_stage #(
  parameter int XLEN    = 32,
  parameter bit PC_PASS = 1'b1
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  rv_decode_stage_if.slave bus
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  function automatic dec_t decode(
    input logic [31:0]     ins,
    input logic [XLEN-1:0] pc
  );
    dec_t        d;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [2:0]  fmt;
    logic [31:0] imm32;
    d     = '0;
    imm32 = '0;
    op    = ins[6:0];
    f3    = ins[14:12];
    unique case (1'b1)
      op == OP_OP,
      RV64 && op == OP_OP32:   fmt = FMT_R;
      op == OP_LOAD,
      op == OP_IMM,
      op == OP_JALR,
      op == OP_FENCE,
      op == OP_SYSTEM,
      RV64 && op == OP_IMM32:  fmt = FMT_I;
      op == OP_STORE:          fmt = FMT_S;
      op == OP_BRANCH:         fmt = FMT_B;
      op == OP_LUI,
      op == OP_AUIPC:          fmt = FMT_U;
      op == OP_JAL:            fmt = FMT_J;
      default:                 fmt = FMT_X;
    endcase
    // Reserved funct3 encodings make otherwise-valid opcodes illegal
    if (ins[1:0] != 2'b11)
      fmt = FMT_X;
    if (op == OP_JALR && f3 != 3'b000)
      fmt = FMT_X;
    if (op == OP_BRANCH && f3[2:1] == 2'b01)
      fmt = FMT_X;

    d.pc      = PC_PASS ? pc : '0;
    d.opcode  = op;
    d.fmt     = fmt;
    d.illegal = (fmt == FMT_X);
    case (fmt)
      FMT_R: begin
        d.rd     = ins[11:7];
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.funct3 = f3;
        d.funct7 = ins[31:25];
      end
      FMT_I: begin
        d.rd     = ins[11:7];
        d.rs1    = ins[19:15];
        d.funct3 = f3;
        imm32    = {{20{ins[31]}}, ins[31:20]};
      end
      FMT_S: begin
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.funct3 = f3;
        imm32    = {{20{ins[31]}}, ins[31:25],
                    ins[11:7]};
      end
      FMT_B: begin
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.funct3 = f3;
        imm32    = {{20{ins[31]}}, ins[7],
                    ins[30:25], ins[11:8], 1'b0};
      end
      FMT_U: begin
        d.rd  = ins[11:7];
        imm32 = {ins[31:12], 12'b0};
      end
      FMT_J: begin
        d.rd  = ins[11:7];
        imm32 = {{12{ins[31]}}, ins[19:12],
                 ins[20], ins[30:21], 1'b0};
      end
      default: ;
    endcase
    d.imm       = {XLEN{imm32[31]}};
    d.imm[31:0] = imm32;
    return d;
  endfunction

  dec_t main_q, main_d;
  dec_t skid_q, skid_d;
  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q, in_ready_d;
  dec_t dec_in;
  logic in_xfer;
  logic main_free;

  always_comb begin
    dec_in       = decode(bus.in_instr, bus.in_pc);
    in_xfer      = bus.in_valid & in_ready_q;
    main_free    = ~main_valid_q | bus.out_ready;
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      // Skid drains first so order is preserved
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = in_xfer;
        if (in_xfer)
          skid_d = dec_in;
      end else begin
        main_valid_d = in_xfer;
        if (in_xfer)
          main_d = dec_in;
      end
    end else if (in_xfer) begin
      skid_d       = dec_in;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_funct3  = main_q.funct3;
  assign bus.out_funct7  = main_q.funct7;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;

endmodule
